// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline sequencer state, the enable/flush
// bundle and the hazard priority encoder used once the MEM stage is not frozen.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {RUN, MEMWAIT, HALT} pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

    // Redirect beats load-use, which beats an instruction-cache miss.
    function automatic pipe_ctrl_t flow_ctrl(input logic redirect, input logic load_use,
                                             input logic ihit);
        pipe_ctrl_t c;
        c = pipe_ctrl_t'(7'b11111_00);
        if (redirect) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end else if (!ihit) begin
            c.pc_en      = 1'b0;
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch enable/flush outputs of the pipeline sequencer.
// master drives the hazard side, slave is the sequencer itself.
interface pipeline_ctrl_if;
    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     mem_dREN;
    logic     mem_dWEN;
    logic     mem_halt;
    logic     ex_dREN;
    regbits_t ex_wsel;
    regbits_t id_rs;
    regbits_t id_rt;
    logic     id_uses_rt;
    logic     ex_redirect;

    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     halted;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_wsel, id_rs, id_rt,
               id_uses_rt, ex_redirect,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_wsel, id_rs, id_rt,
               id_uses_rt, ex_redirect,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted
    );

endinterface

// File: rtl/load_use_detect.sv
// Flags a decode-stage read of the register a load in EX is about to write.
// $0 is hardwired to zero and therefore never a hazard.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dREN,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     load_use
);

    assign load_use = ex_dREN && (ex_wsel != '0) &&
                      ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: MEM-wait freeze, halt parking,
// redirect and load-use bubbles. Define PIPE_PERF_EN to add stall/flush counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
`ifdef PIPE_PERF_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic              CLK,
    input  logic              RST,
`ifdef PIPE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    pipeline_ctrl_if.slave    pif
);

    pipe_state_t state_q, state_d;
    pipe_ctrl_t  ctl;
    logic        load_use;
    logic        mem_req;

    load_use_detect u_load_use_detect (
        .ex_dREN    (pif.ex_dREN),
        .ex_wsel    (pif.ex_wsel),
        .id_rs      (pif.id_rs),
        .id_rt      (pif.id_rt),
        .id_uses_rt (pif.id_uses_rt),
        .load_use   (load_use)
    );

    assign mem_req = pif.mem_dREN | pif.mem_dWEN;

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (pif.mem_halt) begin
                    state_d = HALT;
                end else if (mem_req && !pif.dhit) begin
                    state_d = MEMWAIT;
                end else begin
                    ctl = flow_ctrl(pif.ex_redirect, load_use, pif.ihit);
                end
            end
            MEMWAIT: begin
                if (pif.dhit) begin
                    ctl     = flow_ctrl(pif.ex_redirect, load_use, pif.ihit);
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
        // Latches must see no enables while reset is held.
        if (RST) begin
            ctl = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pif.pc_en      = ctl.pc_en;
    assign pif.ifid_en    = ctl.ifid_en;
    assign pif.idex_en    = ctl.idex_en;
    assign pif.exmem_en   = ctl.exmem_en;
    assign pif.memwb_en   = ctl.memwb_en;
    assign pif.ifid_flush = ctl.ifid_flush;
    assign pif.idex_flush = ctl.idex_flush;
    assign pif.halted     = (state_q == HALT);

`ifdef PIPE_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctl.pc_en && (state_q != HALT)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ctl.ifid_flush || ctl.idex_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of the
// stall/flush rules; optional counter checks when PIPE_PERF_EN is defined.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    localparam logic [7:0] O_RUN   = 8'b1111_1000;
    localparam logic [7:0] O_LDU   = 8'b0011_1010;
    localparam logic [7:0] O_NOHIT = 8'b0111_1100;
    localparam logic [7:0] O_REDIR = 8'b1111_1110;
    localparam logic [7:0] O_FRZ   = 8'b0000_0000;
    localparam logic [7:0] O_HALT  = 8'b0000_0001;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: frozen on a data-memory wait, parked after halt.
    bit          m_wait;
    bit          m_park;
    int          park_cycles;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic [7:0]  exp_out;
    logic [7:0]  outs;

    pipeline_ctrl_if pif ();

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .pif       (pif)
    );
`else
    pipeline_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .pif (pif)
    );
`endif

    always #5 CLK = ~CLK;

    assign outs = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                   pif.ifid_flush, pif.idex_flush, pif.halted};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        pif.ihit = 1'b1;        pif.dhit = 1'b0;       pif.mem_dREN = 1'b0;
        pif.mem_dWEN = 1'b0;    pif.mem_halt = 1'b0;   pif.ex_dREN = 1'b0;
        pif.ex_wsel = '0;       pif.id_rs = '0;        pif.id_rt = '0;
        pif.id_uses_rt = 1'b0;  pif.ex_redirect = 1'b0;
    endtask

    // Inputs are set just after a falling edge; check, then move to the next one.
    task automatic step(input string tag, input logic [7:0] exp);
        #1 check_eq(tag, {24'd0, outs}, {24'd0, exp});
        @(negedge CLK);
    endtask

    function automatic logic [7:0] model_out();
        logic hz;
        if (RST) return O_FRZ;
        if (m_park) return O_HALT;
        hz = pif.ex_dREN && (pif.ex_wsel != 0) && ((pif.ex_wsel == pif.id_rs) ||
             (pif.id_uses_rt && (pif.ex_wsel == pif.id_rt)));
        if (m_wait && !pif.dhit) return O_FRZ;
        if (!m_wait && pif.mem_halt) return O_FRZ;
        if (!m_wait && (pif.mem_dREN || pif.mem_dWEN) && !pif.dhit) return O_FRZ;
        if (pif.ex_redirect) return O_REDIR;
        if (hz) return O_LDU;
        if (!pif.ihit) return O_NOHIT;
        return O_RUN;
    endfunction

    task automatic rand_inputs(input bit allow_halt);
        pif.ihit        = ($urandom_range(0, 3) != 0);
        pif.dhit        = ($urandom_range(0, 1) != 0);
        pif.mem_dREN    = ($urandom_range(0, 3) == 0);
        pif.mem_dWEN    = ($urandom_range(0, 5) == 0);
        pif.mem_halt    = allow_halt && ($urandom_range(0, 63) == 0);
        pif.ex_dREN     = ($urandom_range(0, 1) != 0);
        pif.ex_wsel     = regbits_t'($urandom_range(0, 3));
        pif.id_rs       = regbits_t'($urandom_range(0, 3));
        pif.id_rt       = regbits_t'($urandom_range(0, 3));
        pif.id_uses_rt  = ($urandom_range(0, 1) != 0);
        pif.ex_redirect = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        idle();
        #2 check_eq("reset", {24'd0, outs}, 32'd0);
`ifdef PIPE_PERF_EN
        check_eq("reset_stall_cnt", stall_cnt, 32'd0);
        check_eq("reset_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        step("run", O_RUN);

        pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd5; pif.id_rs = 5'd5;
        step("load_use", O_LDU);
        pif.ex_dREN = 1'b0;
        step("load_use_after", O_RUN);
        pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd0; pif.id_rs = 5'd0;
        step("reg0_no_hazard", O_RUN);
        idle();
        pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd7; pif.id_rs = 5'd3; pif.id_rt = 5'd7;
        pif.id_uses_rt = 1'b1;
        step("load_use_rt", O_LDU);
        pif.id_uses_rt = 1'b0;
        step("rt_unused", O_RUN);

        idle();
        pif.mem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) step("memwait", O_FRZ);
        pif.dhit = 1'b1;
        step("memwait_dhit", O_RUN);
        idle();
        step("memwait_back_run", O_RUN);
        pif.mem_dWEN = 1'b1; pif.dhit = 1'b1;
        step("mem_same_cycle_hit", O_RUN);
        idle();
        step("mem_no_wait", O_RUN);

        pif.ex_redirect = 1'b1; pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd5; pif.id_rs = 5'd5;
        pif.ihit = 1'b0;
        step("redirect_wins", O_REDIR);
        idle();
        pif.ihit = 1'b0;
        step("icache_miss", O_NOHIT);

        idle();
        pif.mem_halt = 1'b1;
        step("halt_entry", O_FRZ);
        for (int i = 0; i < 12; i++) begin
            rand_inputs(1'b1);
            step("halted", O_HALT);
        end
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 check_eq("rst_async_halt", {24'd0, outs}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        idle();
        step("after_halt_reset", O_RUN);

`ifdef PIPE_PERF_EN
        RST = 1'b1;
        #1 check_eq("perf_clear", stall_cnt, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd5; pif.id_rs = 5'd5;
        step("perf_load_use", O_LDU);
        idle();
        step("perf_gap", O_RUN);
        pif.ex_redirect = 1'b1;
        step("perf_redirect", O_REDIR);
        idle();
        check_eq("perf_stall_cnt", stall_cnt, 32'd1);
        check_eq("perf_flush_cnt", flush_cnt, 32'd2);
`endif

        // Randomized traffic against the model, with occasional resets.
        m_wait = 0; m_park = 0; park_cycles = 0; m_stall = '0; m_flush = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            RST = (park_cycles > 12) || ($urandom_range(0, 199) == 0) || (cyc == 0);
            rand_inputs(!m_wait);
            #1;
            if (RST) begin
                m_wait = 0; m_park = 0; park_cycles = 0; m_stall = '0; m_flush = '0;
            end
            exp_out = model_out();
            check_eq("rand_outputs", {24'd0, outs}, {24'd0, exp_out});
`ifdef PIPE_PERF_EN
            check_eq("rand_stall_cnt", stall_cnt, m_stall);
            check_eq("rand_flush_cnt", flush_cnt, m_flush);
`endif
            @(posedge CLK);
            if (!RST) begin
                if (!exp_out[7] && !m_park) m_stall++;
                if (exp_out[2] || exp_out[1]) m_flush++;
                if (!m_park) begin
                    if (m_wait) m_wait = !pif.dhit;
                    else if (pif.mem_halt) m_park = 1;
                    else if ((pif.mem_dREN || pif.mem_dWEN) && !pif.dhit) m_wait = 1;
                end
                park_cycles = m_park ? park_cycles + 1 : 0;
            end
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It takes cache hit signals, hazard operands from the decode and execute stages, and redirect/halt indications. From these it drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It holds a small state machine that freezes the pipe during data-memory waits and parks it permanently after a halt.

## Interface
Parameters:
- CNT_W, 32, width of performance counters (only with PIPE_PERF_EN)

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction cache returned valid instruction this cycle
- dhit  in  1  data cache completed MEM-stage access this cycle
- mem_dREN, mem_dWEN  in  1 each  MEM-stage access request (EX/MEM outputs)
- mem_halt  in  1  halt instruction present in MEM stage
- ex_dREN  in  1  load present in EX stage (ID/EX dREN_out)
- ex_wsel  in  5 (regbits_t)  EX-stage destination register
- id_rs, id_rt  in  5 (regbits_t)  decode-stage source registers
- id_uses_rt  in  1  decode instruction reads rt
- ex_redirect  in  1  taken branch or jump resolved in EX
- pc_en  out  1  PC load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush  out  1 each  latch loads a bubble (all-zero control)
- halted  out  1  pipeline parked after halt
- stall_cnt, flush_cnt  out  CNT_W each  (PIPE_PERF_EN only)

## Operation
- States: RUN, MEMWAIT, HALT (enum pipe_state_t).
- mem_req = mem_dREN | mem_dWEN.
- load_use = ex_dREN & (ex_wsel != 0) & ((ex_wsel == id_rs) | (id_uses_rt & ex_wsel == id_rt)).

RUN, evaluated in priority order:
  1. mem_halt: all enables 0 and all flushes 0. Next state is HALT.
  2. mem_req & !dhit: all enables 0 (full freeze). Next state is MEMWAIT.
  3. ex_redirect:
     - pc_en=1, all latch enables 1.
     - ifid_flush=1, idex_flush=1.
     - This case wins over load_use and !ihit.
  4. load_use:
     - pc_en=0, ifid_en=0.
     - idex_en=1, idex_flush=1.
     - exmem_en=1, memwb_en=1.
  5. !ihit:
     - pc_en=0.
     - ifid_en=1, ifid_flush=1.
     - All other enables 1.
  6. Otherwise all enables 1 and all flushes 0.

MEMWAIT:
- While !dhit, all enables are 0.
- On dhit, the RUN rules 3–6 apply this cycle and the next state is RUN.
- mem_halt cannot arrive in MEMWAIT, because the MEM stage is frozen.

HALT:
- All enables and flushes are 0 and halted=1.
- HALT is sticky until RST.

Further rules:
- A redirect or load-use hazard present during a freeze is held in its latch and acted on when the freeze ends.
- Outputs are never asserted in any combination other than those listed above.

## Timing
- Control outputs are combinational from state and inputs. Latches and the PC sample them at the next CLK edge. The controller adds zero cycles of latency.
- The state register updates on the CLK rising edge.
- While RST is high:
  - state is RUN;
  - every enable and flush is 0 and halted=0;
  - counters are 0.
- RST asserted mid-MEMWAIT or in HALT returns the block to RUN immediately (asynchronously).
- Stall and wait rules:
  - A load-use stall lasts exactly 1 cycle, because the load leaves EX and the bubble sits in ID/EX.
  - A MEMWAIT freeze lasts N cycles for a dhit arriving N cycles after the request. It lasts 0 cycles if dhit occurs in the same cycle as the request.
  - A redirect costs exactly 2 bubbles (IF/ID and ID/EX).

## Configuration
- PIPE_PERF_EN defined:
  - stall_cnt increments on every CLK edge on which pc_en=0 and state≠HALT.
  - flush_cnt increments on every edge on which ifid_flush|idex_flush is 1.
  - Both counters wrap modulo 2^CNT_W and are cleared by RST.
- PIPE_PERF_EN undefined: the counters, the CNT_W logic and the stall_cnt/flush_cnt ports are absent.

## Structure
- pipe_state_t (RUN, MEMWAIT, HALT) is added to cpu_types_pkg. regbits_t is reused from the same package.
- One sub-module, load_use_detect, takes ex_dREN, ex_wsel, id_rs, id_rt and id_uses_rt and outputs load_use. It is purely combinational.
- The FSM, priority encoder and counters live in pipeline_ctrl.

## Test plan
- Load-use hazard:
  - Stimulus: ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1.
  - Response: for one cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. When ex_dREN drops the next cycle, all enables are 1.
- Register $0 is never a hazard:
  - Stimulus: ex_wsel=0, id_rs=0, ex_dREN=1.
  - Response: no stall, all enables 1.
- Data-memory wait:
  - Stimulus: mem_dREN=1, dhit low for 3 cycles, then high.
  - Response: 3 cycles with all enables 0 (state MEMWAIT). On the dhit cycle all enables are 1, then the state returns to RUN.
- Redirect against load-use and !ihit:
  - Stimulus: ex_redirect=1 with load_use=1 and ihit=0.
  - Response: pc_en=1, ifid_flush=1, idex_flush=1.
- Halt, then reset:
  - Stimulus: mem_halt=1.
  - Response: the next cycle halted=1 and all enables 0 for 10+ cycles regardless of inputs. Pulsing RST mid-HALT clears halted immediately.
- Performance counters (PIPE_PERF_EN):
  - Stimulus: run the load-use scenario, then the redirect scenario.
  - Response: stall_cnt=1 and flush_cnt=2.
